booth_acc: RTL and testbench

Sequential accumulation stage directly downstream of the combinational 6-bit Booth multiplier. It accepts the multiplier's 12-bit two's-complement products over a valid/ready handshake and sums LEN consecutive products into a saturating signed accumulator. It then presents the dot-product result over a second valid/ready handshake. It gives the datapath a registered, flow-controlled boundary after the purely combinational multiplier.

---
 rtl/booth_acc_if.sv | 24 ++
 rtl/booth_acc.sv | 147 ++++++++++++++
 tb/tb_booth_acc.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/booth_acc_if.sv
// booth_acc_if: product-in and result-out valid/ready bundle
// master = producer/consumer side, slave = accumulator side
interface booth_acc_if #(
    parameter int WIDTH     = 6,
    parameter int ACC_WIDTH = 14
);
    logic                   in_valid;
    logic                   in_ready;
    logic [2*WIDTH-1:0]     prod;
    logic                   out_valid;
    logic                   out_ready;
    logic [ACC_WIDTH-1:0]   acc_out;
    logic                   sat;

    modport master (
        output in_valid, prod, out_ready,
        input  in_ready, out_valid, acc_out, sat
    );

    modport slave (
        input  in_valid, prod, out_ready,
        output in_ready, out_valid, acc_out, sat
    );
endinterface

// File: rtl/booth_acc.sv
// booth_acc: saturating dot-product accumulator behind the Booth multiplier
// sums LEN signed products, then holds the result until drained
module booth_acc #(
    parameter int WIDTH     = 6,
    parameter int LEN       = 16,
    parameter int ACC_WIDTH = 14
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    booth_acc_if.slave  bus
);
    localparam int PW = 2 * WIDTH;
    localparam int CW = (LEN > 1) ? $clog2(LEN) : 1;
    localparam int AW = ACC_WIDTH;

    localparam logic [CW-1:0] CNT_LAST = CW'(LEN - 1);
    localparam logic [AW-1:0] ACC_MAX  = {1'b0, {(AW-1){1'b1}}};
    localparam logic [AW-1:0] ACC_MIN  = {1'b1, {(AW-1){1'b0}}};

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [AW-1:0]   acc_q, acc_d;
    logic            sat_r_q, sat_r_d;
    logic [AW-1:0]   acc_out_q, acc_out_d;
    logic            sat_q, sat_d;

    logic            in_ready;
    logic            out_valid;
    logic            accept;
    logic            first_beat;
    logic            last_beat;
    logic [AW-1:0]   prod_ext;
    logic [AW:0]     wide_sum;
    logic            clamp;
    logic [AW-1:0]   beat_sum;
    logic            beat_sat;

    assign accept     = bus.in_valid && in_ready;
    assign first_beat = (cnt_q == '0);
    assign last_beat  = (cnt_q == CNT_LAST);

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.acc_out   = acc_out_q;
    assign bus.sat       = sat_q;

    // State register; reset drops out_valid without waiting for a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ACCUM;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: clr wins, last beat enters HOLD, a drain leaves it.
    always_comb begin
        state_d = state_q;
        if (clr) begin
            state_d = ACCUM;
        end else if (accept && last_beat) begin
            state_d = HOLD;
        end else if (state_q == HOLD && bus.out_ready) begin
            state_d = ACCUM;
        end
    end

    // Handshake outputs; in_ready never depends on in_valid.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state_q)
            ACCUM: begin
                in_ready = !clr;
            end
            HOLD: begin
                out_valid = 1'b1;
                in_ready  = bus.out_ready && !clr;
            end
        endcase
    end

    // One beat of saturating accumulation; first beat of a group loads.
    always_comb begin
        prod_ext = AW'($signed(bus.prod[PW-1:0]));
        wide_sum = {acc_q[AW-1], acc_q} + {prod_ext[AW-1], prod_ext};
        clamp    = (wide_sum[AW] != wide_sum[AW-1]);
        beat_sum = wide_sum[AW-1:0];
        beat_sat = sat_r_q;
        if (first_beat) begin
            beat_sum = prod_ext;
            beat_sat = 1'b0;
        end else if (clamp) begin
            beat_sum = wide_sum[AW] ? ACC_MIN : ACC_MAX;
            beat_sat = 1'b1;
        end
    end

    // Datapath next values: partial sum, beat count and held result.
    always_comb begin
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        sat_r_d   = sat_r_q;
        acc_out_d = acc_out_q;
        sat_d     = sat_q;
        if (clr) begin
            cnt_d     = '0;
            acc_d     = '0;
            sat_r_d   = 1'b0;
            acc_out_d = '0;
            sat_d     = 1'b0;
        end else if (accept) begin
            acc_d   = beat_sum;
            sat_r_d = beat_sat;
            if (last_beat) begin
                cnt_d     = '0;
                acc_out_d = beat_sum;
                sat_d     = beat_sat;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            acc_q     <= '0;
            sat_r_q   <= 1'b0;
            acc_out_q <= '0;
            sat_q     <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            sat_r_q   <= sat_r_d;
            acc_out_q <= acc_out_d;
            sat_q     <= sat_d;
        end
    end
endmodule

// File: tb/tb_booth_acc.sv
// tb_booth_acc: scoreboard bench for booth_acc
// arithmetic reference model feeds a queue, monitor drains it
module tb_booth_acc;
    localparam int WIDTH = 6;
    localparam int LEN   = 16;
    localparam int AW    = 14;
    localparam int MAXV  = 8191;
    localparam int MINV  = -8192;

    typedef struct {
        int val;
        bit sat;
    } exp_t;

    logic clk;
    logic rst_n;
    logic clr;

    booth_acc_if #(.WIDTH(WIDTH), .ACC_WIDTH(AW)) bus ();

    booth_acc #(
        .WIDTH(WIDTH),
        .LEN(LEN),
        .ACC_WIDTH(AW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .clr(clr),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   tmo_cnt = 0;
    int   tmo_seen = 0;

    // Reference model: sample at negedge, apply on the following edge.
    int          m_cnt = 0;
    int          m_sum = 0;
    bit          m_sat = 0;
    logic        s_rstn, s_clr, s_acc;
    logic [11:0] s_prod;
    always begin
        @(negedge clk);
        s_rstn = rst_n;
        s_clr  = clr;
        s_acc  = bus.in_valid && bus.in_ready;
        s_prod = bus.prod;
        @(posedge clk);
        if (!s_rstn) begin
            m_cnt = 0;
            m_sum = 0;
            m_sat = 0;
            q.delete();
        end else if (s_clr) begin
            m_cnt = 0;
            m_sum = 0;
            m_sat = 0;
        end else if (s_acc) begin
            int v;
            v = int'($signed(s_prod));
            if (m_cnt == 0) begin
                m_sum = v;
                m_sat = 0;
            end else begin
                m_sum = m_sum + v;
                if (m_sum > MAXV) begin
                    m_sum = MAXV;
                    m_sat = 1;
                end else if (m_sum < MINV) begin
                    m_sum = MINV;
                    m_sat = 1;
                end
            end
            m_cnt++;
            if (m_cnt == LEN) begin
                exp_t e;
                e.val = m_sum;
                e.sat = m_sat;
                q.push_back(e);
                m_cnt = 0;
            end
        end
    end

    // Monitor: compare handshake and result, pop on drain or clr.
    always @(negedge clk) begin
        checks++;
        if (tmo_cnt != tmo_seen) begin
            errors++;
            tmo_seen = tmo_cnt;
            $display("FAIL timeout: count %0d", tmo_cnt);
        end
        if (!rst_n) begin
            checks += 3;
            if (bus.out_valid !== 1'b0) begin
                errors++;
                $display("FAIL rst_out_valid: got %b want 0", bus.out_valid);
            end
            if (bus.acc_out !== '0) begin
                errors++;
                $display("FAIL rst_acc_out: got %h want 0", bus.acc_out);
            end
            if (bus.sat !== 1'b0) begin
                errors++;
                $display("FAIL rst_sat: got %b want 0", bus.sat);
            end
        end else begin
            logic ev, er;
            ev = (q.size() != 0);
            er = !clr && (!ev || bus.out_ready);
            checks += 2;
            if (bus.out_valid !== ev) begin
                errors++;
                $display("FAIL out_valid: got %b want %b", bus.out_valid, ev);
            end
            if (bus.in_ready !== er) begin
                errors++;
                $display("FAIL in_ready: got %b want %b", bus.in_ready, er);
            end
            if (bus.out_valid === 1'b1 && ev) begin
                int got;
                got = int'($signed(bus.acc_out));
                checks += 2;
                if (got != q[0].val) begin
                    errors++;
                    $display("FAIL acc_out: got %0d want %0d", got, q[0].val);
                end
                if (bus.sat !== q[0].sat) begin
                    errors++;
                    $display("FAIL sat: got %b want %b", bus.sat, q[0].sat);
                end
                if (clr || bus.out_ready) void'(q.pop_front());
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [11:0] p);
        int  n;
        logic ok;
        n  = 0;
        ok = 1'b0;
        bus.in_valid = 1'b1;
        bus.prod     = p;
        while (!ok && n < 200) begin
            @(negedge clk);
            ok = bus.in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!ok) begin
            $display("FAIL send_timeout: got no accept want accept");
            tmo_cnt++;
        end
        bus.in_valid = 1'b0;
    endtask

    function automatic logic [11:0] rprod();
        logic signed [5:0]  a, b;
        logic signed [11:0] r;
        a = 6'($urandom);
        b = 6'($urandom);
        r = a * b;
        return r;
    endfunction

    initial begin
        rst_n         = 1'b0;
        clr           = 1'b0;
        bus.in_valid  = 1'b0;
        bus.prod      = '0;
        bus.out_ready = 1'b1;
        tick(3);
        #1 rst_n = 1'b1;
        tick(1);

        // unit products
        repeat (16) send(12'h001);
        tick(2);

        // positive then negative saturation
        repeat (16) send(12'h400);
        repeat (16) send(12'hC00);
        tick(2);

        // alternating signs with an idle gap after beat 5
        for (int i = 0; i < 16; i++) begin
            send(i[0] ? 12'hC00 : 12'h400);
            if (i == 4) tick(3);
        end
        tick(2);

        // backpressure in HOLD, then drain with a new beat
        bus.out_ready = 1'b0;
        for (int i = 0; i < 16; i++) send(rprod());
        bus.in_valid = 1'b1;
        bus.prod     = 12'h005;
        tick(5);
        bus.out_ready = 1'b1;
        send(12'h005);
        for (int i = 0; i < 15; i++) send(rprod());
        tick(2);

        // clr mid-group with a beat offered
        repeat (7) send(12'h003);
        bus.in_valid = 1'b1;
        bus.prod     = 12'h003;
        clr          = 1'b1;
        tick(1);
        clr          = 1'b0;
        bus.in_valid = 1'b0;
        repeat (16) send(12'h002);
        tick(2);

        // async reset during HOLD
        bus.out_ready = 1'b0;
        repeat (16) send(12'h400);
        @(posedge clk);
        #2 rst_n = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b1;
        tick(1);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 16; i++) send(rprod());
        tick(2);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            bus.in_valid  = ($urandom_range(0, 9) < 7);
            bus.prod      = ($urandom_range(0, 7) == 0) ? 12'(($urandom_range(0, 1) != 0) ? 12'h400 : 12'hC00) : rprod();
            bus.out_ready = ($urandom_range(0, 3) != 0);
            clr           = ($urandom_range(0, 59) == 0);
            tick(1);
        end

        // drain
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        clr           = 1'b0;
        begin
            int n;
            n = 0;
            while (q.size() != 0 && n < 50) begin
                tick(1);
                n++;
            end
            if (q.size() != 0) begin
                $display("FAIL drain_timeout: got %0d pending want 0", q.size());
                tmo_cnt++;
            end
        end
        tick(3);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
